pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit_pkg.sv | 61 ++++++
 rtl/pc_stack_unit_call_stack.sv | 54 +++++
 rtl/pc_stack_unit.sv | 85 ++++++++
 tb/tb_pc_stack_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_unit_pkg.sv
// rtl/pc_stack_unit_pkg.sv - shared op encodings and control decode for the PC/stack unit
package pc_stack_unit_pkg;

  // Operation encodings shared with the control unit that issues them.
  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  // Where the next program counter value comes from.
  typedef enum logic [1:0] {
    PC_SRC_NEXT   = 2'b00,
    PC_SRC_TARGET = 2'b01,
    PC_SRC_RETURN = 2'b10
  } pc_src_t;

  // Per-cycle control bundle derived from the op and the stack state.
  typedef struct packed {
    logic    push;
    logic    pop;
    pc_src_t pc_src;
    logic    set_ovf;
    logic    set_unf;
  } ctrl_t;

  // A CALL into a full stack or a RET from an empty one degrades to an INC
  // and raises the matching sticky flag; the stack itself is never touched.
  function automatic ctrl_t decode_op(input op_t op, input logic full, input logic empty);
    ctrl_t c;
    c.push    = 1'b0;
    c.pop     = 1'b0;
    c.pc_src  = PC_SRC_NEXT;
    c.set_ovf = 1'b0;
    c.set_unf = 1'b0;
    case (op)
      OP_INC:  c.pc_src = PC_SRC_NEXT;
      OP_JUMP: c.pc_src = PC_SRC_TARGET;
      OP_CALL: begin
        if (full) begin
          c.set_ovf = 1'b1;
        end else begin
          c.push   = 1'b1;
          c.pc_src = PC_SRC_TARGET;
        end
      end
      OP_RET: begin
        if (empty) begin
          c.set_unf = 1'b1;
        end else begin
          c.pop    = 1'b1;
          c.pc_src = PC_SRC_RETURN;
        end
      end
      default: c.pc_src = PC_SRC_NEXT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_stack_unit_call_stack.sv
// rtl/pc_stack_unit_call_stack.sv - LIFO return-address stack with combinational top-of-stack read
module call_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  wdata,
  output logic [AW-1:0]  rdata,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  // Entries are deliberately left unreset: nothing can read them until
  // they have been written, because sp starts at zero.
  logic [AW-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign full   = (sp == SP_MAX);
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SP_ONE);

  // Top of stack is entry sp-1; report zero when nothing is stacked.
  assign rdata = empty ? '0 : mem[rd_idx];

  // Occupancy counter; the caller never asserts push and pop together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp - SP_ONE;
    end
  end

  // Storage write at the current occupancy slot.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with call/return stack and sticky overflow/underflow flags
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [AW-1:0]  target,
  output logic [AW-1:0]  pc,
  output logic [SPW-1:0] sp,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           unf
);

  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_load;
  logic [AW-1:0] ret_addr;
  ctrl_t         ctrl;

  // Sequential PC, wrapping silently at the top of the address space.
  assign pc_next = pc + AW'(1);

  // Decode is gated by en so a stall leaves the stack untouched.
  always_comb begin
    ctrl = '0;
    if (en) begin
      ctrl = decode_op(op_t'(op), full, empty);
    end
  end

  // Select the value the PC takes on the next enabled edge.
  always_comb begin
    pc_load = pc_next;
    case (ctrl.pc_src)
      PC_SRC_NEXT:   pc_load = pc_next;
      PC_SRC_TARGET: pc_load = target;
      PC_SRC_RETURN: pc_load = ret_addr;
      default:       pc_load = pc_next;
    endcase
  end

  // Program counter register; only registered state reaches pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc_load;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ctrl.set_ovf) ovf <= 1'b1;
      if (ctrl.set_unf) unf <= 1'b1;
    end
  end

  call_stack #(
    .AW   (AW),
    .DEPTH(DEPTH),
    .SPW  (SPW)
  ) u_call_stack (
    .clk  (clk),
    .reset(reset),
    .push (ctrl.push),
    .pop  (ctrl.pop),
    .wdata(pc_next),
    .rdata(ret_addr),
    .sp   (sp),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - randomized and directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int PCMASK = (1 << AW) - 1;

  logic           clk;
  logic           reset;
  logic           en;
  logic [1:0]     op;
  logic [AW-1:0]  target;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           empty;
  logic           full;
  logic           ovf;
  logic           unf;

  int tests;
  int fails;
  bit check_en;

  // Reference model: plain integers and a queue used as a LIFO.
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .op    (op),
    .target(target),
    .pc    (pc),
    .sp    (sp),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit e, input int o, input int t);
    if (e) begin
      case (o)
        0: m_pc = (m_pc + 1) & PCMASK;
        1: m_pc = t;
        2: begin
          if (m_stk.size() == DEPTH) begin
            m_ovf = 1;
            m_pc  = (m_pc + 1) & PCMASK;
          end else begin
            m_stk.push_back((m_pc + 1) & PCMASK);
            m_pc = t;
          end
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_unf = 1;
            m_pc  = (m_pc + 1) & PCMASK;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
  endtask

  // Issue one op for one edge, then advance the model to match.
  task automatic step(input bit e, input int o, input int t);
    en     = e;
    op     = 2'(o);
    target = AW'(t);
    @(posedge clk);
    model_step(e, o, t);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_pc", int'(pc), 0);
    chk("async_reset_sp", int'(sp), 0);
    chk("async_reset_ovf", int'(ovf), 0);
    chk("async_reset_unf", int'(unf), 0);
    reset = 1'b0;
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("cmp_pc", int'(pc), m_pc);
      chk("cmp_sp", int'(sp), m_stk.size());
      chk("cmp_empty", int'(empty), int'(m_stk.size() == 0));
      chk("cmp_full", int'(full), int'(m_stk.size() == DEPTH));
      chk("cmp_ovf", int'(ovf), int'(m_ovf));
      chk("cmp_unf", int'(unf), int'(m_unf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    check_en = 0;
    reset    = 1'b1;
    en       = 1'b0;
    op       = 2'b00;
    target   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("reset_pc", int'(pc), 0);
    chk("reset_sp", int'(sp), 0);
    chk("reset_empty", int'(empty), 1);
    reset = 1'b0;
    check_en = 1;

    // Three increments from reset.
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0);
      chk("inc_pc", int'(pc), i);
    end
    chk("inc_sp", int'(sp), 0);
    chk("inc_empty", int'(empty), 1);

    // Call and return.
    step(1, 1, 5);
    step(1, 2, 'h100);
    chk("call_pc", int'(pc), 'h100);
    chk("call_sp", int'(sp), 1);
    step(1, 3, 0);
    chk("ret_pc", int'(pc), 6);
    chk("ret_sp", int'(sp), 0);

    // Nested calls up to full, an overflow attempt, then unwind.
    step(1, 1, 1);
    step(1, 2, 'h10);
    step(1, 2, 'h20);
    step(1, 2, 'h30);
    step(1, 2, 'h40);
    chk("nest_full", int'(full), 1);
    chk("nest_sp", int'(sp), 4);
    chk("nest_pc", int'(pc), 'h40);
    step(1, 2, 'h200);
    chk("ovf_pc", int'(pc), 'h41);
    chk("ovf_sp", int'(sp), 4);
    chk("ovf_flag", int'(ovf), 1);
    step(1, 3, 0);
    chk("unwind_pc0", int'(pc), 'h31);
    step(1, 3, 0);
    chk("unwind_pc1", int'(pc), 'h21);
    step(1, 3, 0);
    chk("unwind_pc2", int'(pc), 'h11);
    step(1, 3, 0);
    chk("unwind_pc3", int'(pc), 2);
    chk("unwind_empty", int'(empty), 1);

    // Underflow at the top of the address space wraps to zero.
    step(1, 1, 'h3FF);
    step(1, 3, 0);
    chk("unf_pc", int'(pc), 0);
    chk("unf_flag", int'(unf), 1);

    // Stalls hold everything even with a CALL presented.
    for (int i = 0; i < 3; i++) step(0, 2, 'h155);
    chk("stall_pc", int'(pc), 0);
    chk("stall_sp", int'(sp), 0);
    chk("stall_ovf", int'(ovf), 1);
    chk("stall_unf", int'(unf), 1);

    // Reset between edges with two entries stacked and ovf set.
    step(1, 2, 'h50);
    step(1, 2, 'h60);
    chk("pre_reset_sp", int'(sp), 2);
    mid_reset();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(9) != 0), int'($urandom_range(3)), int'($urandom_range(PCMASK)));
      if ($urandom_range(99) == 0) mid_reset();
    end

    check_en = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
